// File: rtl/bcd_count_pkg.sv
// Shared widths, limits and BCD conversion helpers for the two-digit BCD counter.
package bcd_count_pkg;

  localparam int BCD_W = 4;
  localparam int LIM_W = 7;

  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [LIM_W-1:0] CNT_MAX       = 7'd99;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Repeated subtraction keeps this a small comparator chain rather than a divider.
  function automatic bcd2_t bin_to_bcd2(input logic [LIM_W-1:0] bin);
    logic [LIM_W-1:0] rem;
    bcd2_t            res;
    rem      = (bin > CNT_MAX) ? CNT_MAX : bin;
    res.tens = '0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem      = rem - 7'd10;
        res.tens = res.tens + 4'd1;
      end
    end
    res.ones = 4'(rem);
    return res;
  endfunction

  function automatic logic [LIM_W-1:0] bcd2_to_bin(input bcd2_t bcd);
    return (7'(bcd.tens) * 7'd10) + 7'(bcd.ones);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0..9) register with synchronous clear, load and increment, plus carry out.
module bcd_digit
  import bcd_count_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] digit_q, digit_d;

  // NOTE: default assignment first so every path assigns digit_d and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = (load_val_i > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : load_val_i;
    end else if (inc_i) begin
      digit_d = (digit_q >= BCD_MAX_DIGIT) ? '0 : digit_q + 4'd1;
    end
  end

  // NOTE: non-blocking assignment for registered state avoids simulation races between flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign carry_o = inc_i && (digit_q == BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_count_7.sv
// Programmable two-digit BCD up-counter 00..min(max_count,99), wrapping to 00.
// Define BCD_COUNT_HOLD_EN to saturate at the limit instead of wrapping.
module bcd_count_7
  import bcd_count_pkg::*;
(
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [LIM_W-1:0] max_count,
  input  logic             run,
  output logic [BCD_W-1:0] digit_1,
  output logic [BCD_W-1:0] digit_2
);

  logic [LIM_W-1:0] lim;
  logic [LIM_W-1:0] cnt_bin;
  bcd2_t            cnt;
  bcd2_t            load_bcd;
  logic             clr;
  logic             load;
  logic             ones_inc;
  logic             ones_carry;
  logic             tens_ovf;

  assign lim     = (max_count > CNT_MAX) ? CNT_MAX : max_count;
  assign cnt     = '{tens: digit_2, ones: digit_1};
  assign cnt_bin = bcd2_to_bin(cnt);

`ifdef BCD_COUNT_HOLD_EN
  assign ones_inc = run && (cnt_bin < lim);
  assign load     = run && (cnt_bin > lim);
  assign load_bcd = bin_to_bcd2(lim);
  assign clr      = !run || tens_ovf;
`else
  // Clear wins over increment inside the digit, so ones_inc can simply follow run.
  assign ones_inc = run;
  assign load     = 1'b0;
  assign load_bcd = '0;
  assign clr      = !run || (cnt_bin >= lim) || tens_ovf;
`endif

  // tens_ovf is unreachable while lim <= 99; it only guards tens against rolling past 9.
  bcd_digit u_ones (
    .clk        (CLK),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .inc_i      (ones_inc),
    .load_i     (load),
    .load_val_i (load_bcd.ones),
    .digit_o    (digit_1),
    .carry_o    (ones_carry)
  );

  bcd_digit u_tens (
    .clk        (CLK),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .inc_i      (ones_carry),
    .load_i     (load),
    .load_val_i (load_bcd.tens),
    .digit_o    (digit_2),
    .carry_o    (tens_ovf)
  );

endmodule

// File: tb/tb_bcd_count_7.sv
// Directed self-checking bench for bcd_count_7; outputs sampled 1 ns after each rising CLK.
module tb_bcd_count_7;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [6:0] max_count;
  logic       run;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic [7:0] q;

  int checks = 0;
  int errors = 0;

  bcd_count_7 dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .max_count (max_count),
    .run       (run),
    .digit_1   (digit_1),
    .digit_2   (digit_2)
  );

  always #10 CLK = ~CLK;

  assign q = {digit_2, digit_1};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    max_count = 7'd10;
    #5;
    check("reset", q, 8'h00);
    @(negedge CLK);
    rst_n = 1'b1;

    // Count to 10 and past it.
    run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("cnt10", q, to_bcd(i));
    end
    tick();
`ifdef BCD_COUNT_HOLD_EN
    check("cnt10_hold", q, 8'h10);
    tick();
    check("cnt10_hold2", q, 8'h10);
`else
    check("cnt10_wrap", q, 8'h00);
    tick();
    check("cnt10_after_wrap", q, 8'h01);
`endif

    // Asynchronous reset mid-count at 07.
    run = 1'b0;
    tick();
    check("clr_before_rst", q, 8'h00);
    run = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    check("at07", q, 8'h07);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_rst", q, 8'h00);
    tick();
    check("rst_held", q, 8'h00);
    rst_n = 1'b1;
    tick();
    check("resume01", q, 8'h01);

    // run=0 acts as a synchronous clear.
    for (int i = 2; i <= 5; i++) tick();
    check("at05", q, 8'h05);
    run = 1'b0;
    tick();
    check("run_clear", q, 8'h00);
    run = 1'b1;
    tick();
    check("run_restart", q, 8'h01);

    // Limit lowered below current count.
    max_count = 7'd26;
    for (int i = 2; i <= 14; i++) tick();
    check("at14", q, 8'h14);
    max_count = 7'd10;
    tick();
`ifdef BCD_COUNT_HOLD_EN
    check("lowered_load", q, 8'h10);
    tick();
    check("lowered_hold", q, 8'h10);
`else
    check("lowered_wrap", q, 8'h00);
    for (int i = 1; i <= 10; i++) tick();
    check("lowered_to10", q, 8'h10);
    tick();
    check("lowered_wrap2", q, 8'h00);
`endif

    // Limit above 99 clamps to 99.
    run = 1'b0;
    tick();
    max_count = 7'd127;
    run       = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      tick();
      check("clamp", q, to_bcd(i));
    end
    tick();
`ifdef BCD_COUNT_HOLD_EN
    check("clamp_hold", q, 8'h99);
`else
    check("clamp_wrap", q, 8'h00);
`endif

    // Zero limit keeps the count at 00.
    run = 1'b0;
    tick();
    run       = 1'b1;
    max_count = 7'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_lim", q, 8'h00);
    end

`ifdef BCD_COUNT_HOLD_EN
    max_count = 7'd6;
    for (int i = 1; i <= 6; i++) tick();
    check("hold6", q, 8'h06);
    tick();
    check("hold6_stay", q, 8'h06);
    max_count = 7'd4;
    tick();
    check("hold_lower4", q, 8'h04);
    run = 1'b0;
    tick();
    check("hold_clear", q, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
